// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control and mult/div busy counter.
// Define HAZ_STALL_CNT_EN to add the Stall_Cnt stall-cycle counter.
module hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] D_Instr,
  input  logic [31:0] E_Instr,
  input  logic [31:0] M_Instr,
  input  logic [31:0] W_Instr,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic [4:0]  W_A3,
  output logic        PC_Enable,
  output logic        RegD_Enable,
  output logic        RegE_Clr,
  output logic [2:0]  MFRD1D,
  output logic [2:0]  MFRD2D,
  output logic [2:0]  MFALUAE,
  output logic [2:0]  MFALUBE,
  output logic [2:0]  MFWDM,
`ifdef HAZ_STALL_CNT_EN
  output logic [31:0] Stall_Cnt,
`endif
  output logic        MD_Busy
);

  typedef struct packed {
    logic cal_r;
    logic cal_i;
    logic load;
    logic store;
    logic br;
    logic jal;
    logic jr;
    logic md;
    logic mul;
    logic mf;
    logic mt;
  } cls_t;

  function automatic cls_t decode(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    cls_t c;
    logic r;
    c       = '0;
    r       = (op == 6'b000000);
    c.cal_r = r && (fn[5:2] == 4'b1000);
    c.cal_i = (op == 6'b001101) ||
              (op == 6'b001111);
    c.load  = (op == 6'b100011);
    c.store = (op == 6'b101011);
    c.br    = (op == 6'b000100);
    c.jal   = (op == 6'b000011);
    c.jr    = r && (fn == 6'b001000);
    c.md    = r && (fn[5:2] == 4'b0110);
    c.mul   = c.md && !fn[1];
    c.mf    = r && (fn == 6'b010000 ||
                    fn == 6'b010010);
    c.mt    = r && (fn == 6'b010001 ||
                    fn == 6'b010011);
    return c;
  endfunction

  // Priority pick of a forwarding source; a zero code means "not ready".
  function automatic logic [2:0] pick(
    input logic [4:0] src,
    input logic [4:0] ea3,
    input logic [4:0] ma3,
    input logic [4:0] wa3,
    input logic [2:0] ce,
    input logic [2:0] cm,
    input logic [2:0] cw
  );
    logic [2:0] s;
    s = 3'd0;
    if (src != 5'd0) begin
      if (ea3 == src && ce != 3'd0)
        s = ce;
      else if (ma3 == src && cm != 3'd0)
        s = cm;
      else if (wa3 == src && cw != 3'd0)
        s = cw;
    end
    return s;
  endfunction

  function automatic logic haz(
    input logic [4:0] src,
    input logic       used,
    input logic [1:0] tuse,
    input logic [4:0] ea3,
    input logic [4:0] ma3,
    input logic [1:0] tne,
    input logic [1:0] tnm
  );
    return used && (src != 5'd0) &&
      ((ea3 == src && tne > tuse) ||
       (ma3 == src && tnm > tuse));
  endfunction

  cls_t d_c, e_c, m_c, w_c;

  assign d_c = decode(D_Instr[31:26], D_Instr[5:0]);
  assign e_c = decode(E_Instr[31:26], E_Instr[5:0]);
  assign m_c = decode(M_Instr[31:26], M_Instr[5:0]);
  assign w_c = decode(W_Instr[31:26], W_Instr[5:0]);

  logic [4:0] d_rs, d_rt, e_rs, e_rt, m_rt;

  assign d_rs = D_Instr[25:21];
  assign d_rt = D_Instr[20:16];
  assign e_rs = E_Instr[25:21];
  assign e_rt = E_Instr[20:16];
  assign m_rt = M_Instr[20:16];

  logic       rs_use, rt_use;
  logic [1:0] rs_tuse, rt_tuse;

  assign rs_use = d_c.br | d_c.jr | d_c.cal_r |
                  d_c.cal_i | d_c.load |
                  d_c.store | d_c.md | d_c.mt;
  assign rt_use = d_c.br | d_c.cal_r |
                  d_c.store | d_c.md;
  assign rs_tuse = (d_c.br | d_c.jr) ? 2'd0 : 2'd1;
  assign rt_tuse = d_c.br    ? 2'd0 :
                   d_c.store ? 2'd2 : 2'd1;

  logic [1:0] e_tnew, m_tnew;

  assign e_tnew = e_c.load ? 2'd2 :
                  (e_c.cal_r | e_c.cal_i | e_c.mf) ?
                  2'd1 : 2'd0;
  assign m_tnew = m_c.load ? 2'd1 : 2'd0;

  logic reg_stall, md_stall, stall;
  logic d_mdc;

  assign reg_stall =
    haz(d_rs, rs_use, rs_tuse, E_A3, M_A3,
        e_tnew, m_tnew) ||
    haz(d_rt, rt_use, rt_tuse, E_A3, M_A3,
        e_tnew, m_tnew);

  assign d_mdc    = d_c.md | d_c.mf | d_c.mt;
  assign md_stall = d_mdc && (MD_Busy || e_c.md);
  assign stall    = reg_stall | md_stall;

  assign PC_Enable   = ~stall;
  assign RegD_Enable = ~stall;
  assign RegE_Clr    = stall;

  logic m_val, w_val;
  logic [2:0] e_fd, m_fd, w_fd, m_fe, w_fe;

  assign m_val = m_c.cal_r | m_c.cal_i | m_c.mf;
  assign w_val = w_c.cal_r | w_c.cal_i | w_c.mf;

  assign e_fd = e_c.jal ? 3'd1 : 3'd0;
  assign m_fd = m_val     ? 3'd2 :
                m_c.jal   ? 3'd3 : 3'd0;
  assign w_fd = w_val     ? 3'd4 :
                w_c.load  ? 3'd5 :
                w_c.jal   ? 3'd6 : 3'd0;
  assign m_fe = m_val     ? 3'd1 :
                m_c.jal   ? 3'd2 : 3'd0;
  assign w_fe = w_c.load  ? 3'd3 : 3'd0;

  assign MFRD1D  = pick(d_rs, E_A3, M_A3, W_A3,
                        e_fd, m_fd, w_fd);
  assign MFRD2D  = pick(d_rt, E_A3, M_A3, W_A3,
                        e_fd, m_fd, w_fd);
  assign MFALUAE = pick(e_rs, 5'd0, M_A3, W_A3,
                        3'd0, m_fe, w_fe);
  assign MFALUBE = pick(e_rt, 5'd0, M_A3, W_A3,
                        3'd0, m_fe, w_fe);

  assign MFWDM = (m_c.store && w_c.load &&
                  m_rt != 5'd0 && W_A3 == m_rt) ?
                 3'd1 : 3'd0;

  // Busy window opens at the edge the md op leaves E.
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (e_c.md)
      cnt_d = e_c.mul ? 4'(MULT_LAT) : 4'(DIV_LAT);
    else if (cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign MD_Busy = (cnt_q != 4'd0);

`ifdef HAZ_STALL_CNT_EN
  logic [31:0] scnt_q, scnt_d;

  assign scnt_d = stall ? scnt_q + 32'd1 : scnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) scnt_q <= 32'd0;
    else       scnt_q <= scnt_d;
  end

  assign Stall_Cnt = scnt_q;
`endif

  logic unused_bits;

  assign unused_bits = ^{D_Instr[15:6], E_Instr[15:6],
                         M_Instr[25:21], M_Instr[15:6],
                         W_Instr[25:6], d_c.jal, d_c.mul,
                         e_c.store, e_c.br, e_c.jr,
                         e_c.mt, m_c.load, m_c.br,
                         m_c.jr, m_c.md, m_c.mul,
                         m_c.mt, w_c.store, w_c.br,
                         w_c.jr, w_c.md, w_c.mul,
                         w_c.mt};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: random + directed stimulus, scoreboard against
// an instruction-level reference model of hazards and md busy.
module tb_hazard_ctrl;

  localparam int K_NOP = 0, K_CALR = 1, K_CALI = 2;
  localparam int K_LOAD = 3, K_STORE = 4, K_BR = 5;
  localparam int K_JAL = 6, K_JR = 7, K_MD = 8;
  localparam int K_MF = 9, K_MT = 10;
  localparam int LAT_MUL = 5, LAT_DIV = 10;

  logic        Clk, Reset;
  logic [31:0] D_Instr, E_Instr, M_Instr, W_Instr;
  logic [4:0]  E_A3, M_A3, W_A3;
  logic        PC_Enable, RegD_Enable, RegE_Clr;
  logic [2:0]  MFRD1D, MFRD2D, MFALUAE, MFALUBE, MFWDM;
  logic        MD_Busy;
`ifdef HAZ_STALL_CNT_EN
  logic [31:0] Stall_Cnt;
`endif

  hazard_ctrl dut (
    .Clk(Clk), .Reset(Reset),
    .D_Instr(D_Instr), .E_Instr(E_Instr),
    .M_Instr(M_Instr), .W_Instr(W_Instr),
    .E_A3(E_A3), .M_A3(M_A3), .W_A3(W_A3),
    .PC_Enable(PC_Enable), .RegD_Enable(RegD_Enable),
    .RegE_Clr(RegE_Clr),
    .MFRD1D(MFRD1D), .MFRD2D(MFRD2D),
    .MFALUAE(MFALUAE), .MFALUBE(MFALUBE),
    .MFWDM(MFWDM),
`ifdef HAZ_STALL_CNT_EN
    .Stall_Cnt(Stall_Cnt),
`endif
    .MD_Busy(MD_Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        pc, rd, clr;
    logic [2:0]  f1, f2, fa, fb, fw;
    logic        busy;
    logic [31:0] scnt;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_md = -1000, last_lat = 0;
  bit prev_md = 0, prev_stall = 0;
  int prev_lat = 0;
  logic [31:0] scnt_m = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, want, cyc);
    end
  endtask

  function automatic int kind(input logic [31:0] i);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21, 6'h22, 6'h23: return K_CALR;
        6'h08: return K_JR;
        6'h18, 6'h19, 6'h1a, 6'h1b: return K_MD;
        6'h10, 6'h12: return K_MF;
        6'h11, 6'h13: return K_MT;
        default: return K_NOP;
      endcase
    end
    case (op)
      6'h0d, 6'h0f: return K_CALI;
      6'h23: return K_LOAD;
      6'h2b: return K_STORE;
      6'h04: return K_BR;
      6'h03: return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  function automatic int rs_of(input logic [31:0] i);
    return int'(i[25:21]);
  endfunction
  function automatic int rt_of(input logic [31:0] i);
    return int'(i[20:16]);
  endfunction

  function automatic int dest(input logic [31:0] i);
    case (kind(i))
      K_CALR, K_MF: return int'(i[15:11]);
      K_CALI, K_LOAD: return rt_of(i);
      K_JAL: return 31;
      default: return 0;
    endcase
  endfunction

  // -1 means the operand is not read
  function automatic int tuse(input logic [31:0] i,
                              input bit rt);
    case (kind(i))
      K_BR: return 0;
      K_JR: return rt ? -1 : 0;
      K_CALR, K_MD: return 1;
      K_CALI, K_LOAD, K_MT: return rt ? -1 : 1;
      K_STORE: return rt ? 2 : 1;
      default: return -1;
    endcase
  endfunction

  function automatic int tnew_e(input logic [31:0] i);
    case (kind(i))
      K_CALR, K_CALI, K_MF: return 1;
      K_LOAD: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int tnew_m(input logic [31:0] i);
    return kind(i) == K_LOAD ? 1 : 0;
  endfunction

  function automatic logic [2:0] pick(input int src,
      input int ea3, input int ma3, input int wa3,
      input int ce, input int cm, input int cw);
    int a3[3];
    int c[3];
    a3 = '{ea3, ma3, wa3};
    c  = '{ce, cm, cw};
    for (int s = 0; s < 3; s++)
      if (src != 0 && a3[s] == src && c[s] != 0)
        return 3'(c[s]);
    return 3'd0;
  endfunction

  function automatic int code_wd(input logic [31:0] i);
    case (kind(i))
      K_CALR, K_CALI, K_MF: return 4;
      K_LOAD: return 5;
      K_JAL: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic int code_md(input logic [31:0] i);
    case (kind(i))
      K_CALR, K_CALI, K_MF: return 2;
      K_JAL: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] d, e, m, w,
                       input int ea3, ma3, wa3);
    exp_t x;
    bit st, busy, kd;
    int srcs[2];
    @(posedge Clk);
    if (prev_md) begin
      last_md  = cyc;
      last_lat = prev_lat;
    end
    if (prev_stall) scnt_m = scnt_m + 32'd1;
    cyc++;
    #1;
    D_Instr = d; E_Instr = e; M_Instr = m; W_Instr = w;
    E_A3 = 5'(ea3); M_A3 = 5'(ma3); W_A3 = 5'(wa3);
    busy = (cyc - last_md) <= last_lat;
    srcs = '{rs_of(d), rt_of(d)};
    st = 0;
    for (int s = 0; s < 2; s++) begin
      int u;
      u = tuse(d, s == 1);
      if (u >= 0 && srcs[s] != 0) begin
        if (ea3 == srcs[s] && tnew_e(e) > u) st = 1;
        if (ma3 == srcs[s] && tnew_m(m) > u) st = 1;
      end
    end
    kd = kind(d) inside {K_MD, K_MF, K_MT};
    if (kd && (busy || kind(e) == K_MD)) st = 1;
    x.pc   = !st;
    x.rd   = !st;
    x.clr  = st;
    x.f1   = pick(srcs[0], ea3, ma3, wa3,
                  kind(e) == K_JAL ? 1 : 0,
                  code_md(m), code_wd(w));
    x.f2   = pick(srcs[1], ea3, ma3, wa3,
                  kind(e) == K_JAL ? 1 : 0,
                  code_md(m), code_wd(w));
    x.fa   = pick(rs_of(e), 0, ma3, wa3, 0,
                  code_md(m) - (code_md(m) != 0 ? 1 : 0),
                  kind(w) == K_LOAD ? 3 : 0);
    x.fb   = pick(rt_of(e), 0, ma3, wa3, 0,
                  code_md(m) - (code_md(m) != 0 ? 1 : 0),
                  kind(w) == K_LOAD ? 3 : 0);
    x.fw   = (kind(m) == K_STORE && kind(w) == K_LOAD &&
              rt_of(m) != 0 && wa3 == rt_of(m)) ? 3'd1 : 3'd0;
    x.busy = busy;
    x.scnt = scnt_m;
    q.push_back(x);
    prev_md    = kind(e) == K_MD;
    prev_lat   = (e[5:0] == 6'h18 || e[5:0] == 6'h19) ?
                 LAT_MUL : LAT_DIV;
    prev_stall = st;
  endtask

  task automatic drive_a(input logic [31:0] d, e, m, w);
    drive(d, e, m, w, dest(e), dest(m), dest(w));
  endtask

  always @(negedge Clk) begin
    if (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      chk("PC_Enable", 32'(PC_Enable), 32'(x.pc));
      chk("RegD_Enable", 32'(RegD_Enable), 32'(x.rd));
      chk("RegE_Clr", 32'(RegE_Clr), 32'(x.clr));
      chk("MFRD1D", 32'(MFRD1D), 32'(x.f1));
      chk("MFRD2D", 32'(MFRD2D), 32'(x.f2));
      chk("MFALUAE", 32'(MFALUAE), 32'(x.fa));
      chk("MFALUBE", 32'(MFALUBE), 32'(x.fb));
      chk("MFWDM", 32'(MFWDM), 32'(x.fw));
      chk("MD_Busy", 32'(MD_Busy), 32'(x.busy));
`ifdef HAZ_STALL_CNT_EN
      chk("Stall_Cnt", Stall_Cnt, x.scnt);
`endif
    end
  end

  function automatic logic [31:0] r_ins(input int rs, rt, rd,
                                        input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op,
                                        input int rs, rt);
    return {op, 5'(rs), 5'(rt), 16'h0040};
  endfunction

  function automatic int rreg();
    int v;
    v = int'($urandom_range(0, 4));
    return v == 4 ? 31 : v;
  endfunction

  function automatic logic [31:0] rnd_ins();
    logic [5:0] fn;
    fn = 6'($urandom_range(0, 3));
    case ($urandom_range(0, 12))
      0, 12: return r_ins(rreg(), rreg(), rreg(),
                          6'h20 | fn);
      1: return i_ins($urandom_range(0, 1) ? 6'h0d : 6'h0f,
                      rreg(), rreg());
      2: return i_ins(6'h23, rreg(), rreg());
      3: return i_ins(6'h2b, rreg(), rreg());
      4: return i_ins(6'h04, rreg(), rreg());
      5: return {6'h03, 26'($urandom)};
      6: return r_ins(rreg(), 0, 0, 6'h08);
      7: return r_ins(rreg(), rreg(), 0, 6'h18 | fn);
      8: return r_ins(0, 0, rreg(),
                      $urandom_range(0, 1) ? 6'h10 : 6'h12);
      9: return r_ins(rreg(), 0, 0,
                      $urandom_range(0, 1) ? 6'h11 : 6'h13);
      10: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  function automatic int ra3(input logic [31:0] i);
    return $urandom_range(0, 9) == 0 ? 0 : dest(i);
  endfunction

  task automatic md_seq(input logic [31:0] op, input int lat);
    logic [31:0] mflo;
    mflo = r_ins(0, 0, 7, 6'h12);
    drive_a(mflo, op, 0, 0);
    #2 chk("md_e_stall", 32'(PC_Enable), 32'd0);
    for (int k = 1; k <= lat; k++) begin
      drive_a(mflo, 0, 0, 0);
      #2;
      chk("md_busy_on", 32'(MD_Busy), 32'd1);
      chk("md_busy_stall", 32'(PC_Enable), 32'd0);
    end
    drive_a(mflo, 0, 0, 0);
    #2;
    chk("md_busy_off", 32'(MD_Busy), 32'd0);
    chk("md_release", 32'(PC_Enable), 32'd1);
  endtask

  initial begin
    logic [31:0] lw1, add2, addu4, beq4, jal_i, jr31;
    logic [31:0] sw5, lw5, divx;
    Reset = 1'b1;
    D_Instr = '0; E_Instr = '0; M_Instr = '0; W_Instr = '0;
    E_A3 = '0; M_A3 = '0; W_A3 = '0;
    #1;
    chk("rst_pc", 32'(PC_Enable), 32'd1);
    chk("rst_regd", 32'(RegD_Enable), 32'd1);
    chk("rst_clr", 32'(RegE_Clr), 32'd0);
    chk("rst_sel", 32'({MFRD1D, MFRD2D, MFALUAE, MFALUBE,
                        MFWDM}), 32'd0);
    chk("rst_busy", 32'(MD_Busy), 32'd0);
    #2 Reset = 1'b0;

    lw1   = i_ins(6'h23, 0, 1);
    add2  = r_ins(1, 3, 2, 6'h20);
    addu4 = r_ins(5, 6, 4, 6'h21);
    beq4  = i_ins(6'h04, 4, 0);
    jal_i = {6'h03, 26'h0000100};
    jr31  = r_ins(31, 0, 0, 6'h08);
    sw5   = i_ins(6'h2b, 0, 5);
    lw5   = i_ins(6'h23, 0, 5);
    divx  = r_ins(1, 2, 0, 6'h1a);

    drive_a(add2, lw1, 0, 0);
    #2;
    chk("lu_pc", 32'(PC_Enable), 32'd0);
    chk("lu_regd", 32'(RegD_Enable), 32'd0);
    chk("lu_clr", 32'(RegE_Clr), 32'd1);
    drive_a(add2, 0, lw1, 0);
    #2 chk("lu_go", 32'(PC_Enable), 32'd1);

    drive_a(beq4, 0, addu4, 0);
    #2;
    chk("beq_nostall", 32'(PC_Enable), 32'd1);
    chk("beq_fwd_m", 32'(MFRD1D), 32'd2);
    drive_a(beq4, addu4, 0, 0);
    #2 chk("beq_stall", 32'(RegE_Clr), 32'd1);

    drive(jr31, jal_i, 0, 0, 31, 0, 0);
    #2;
    chk("jr_fwd_e", 32'(MFRD1D), 32'd1);
    chk("jr_nostall", 32'(PC_Enable), 32'd1);

    drive(0, 0, sw5, lw5, 0, 0, 5);
    #2 chk("wdm_on", 32'(MFWDM), 32'd1);
    drive(0, 0, sw5, lw5, 0, 0, 0);
    #2 chk("wdm_a3zero", 32'(MFWDM), 32'd0);

    md_seq(r_ins(1, 2, 0, 6'h18), LAT_MUL);
    md_seq(divx, LAT_DIV);

    drive_a(0, divx, 0, 0);
    for (int k = 0; k < 4; k++) drive_a(0, 0, 0, 0);
    @(negedge Clk);
    #1;
    D_Instr = '0; E_Instr = '0; M_Instr = '0; W_Instr = '0;
    E_A3 = '0; M_A3 = '0; W_A3 = '0;
    Reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(MD_Busy), 32'd0);
`ifdef HAZ_STALL_CNT_EN
    chk("async_rst_scnt", Stall_Cnt, 32'd0);
`endif
    last_md = -1000; last_lat = 0;
    prev_md = 0; prev_stall = 0; scnt_m = 0;
    #1 Reset = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] d, e, m, w;
      d = rnd_ins(); e = rnd_ins();
      m = rnd_ins(); w = rnd_ins();
      drive(d, e, m, w, ra3(e), ra3(m), ra3(w));
    end

    @(posedge Clk);
    #1 chk("sb_drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
